// File: rtl/auth_pkg.sv
// Shared types and constants for the rider-authorisation controller.
package auth_pkg;

    // Controller states; any other 3-bit pattern is treated as OFF.
    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_KEY      = 3'd1,
        ST_ON       = 3'd2,
        ST_STOPPING = 3'd3,
        ST_LOCKED   = 3'd4
    } state_t;

    localparam logic [7:0] DEF_GO_CODE   = 8'h67;
    localparam logic [7:0] DEF_STOP_CODE = 8'h73;

    // Width of the shared timer: wide enough to hold the largest limit.
    function automatic int tmr_w(input int hb, input int to, input int lock);
        int m;
        m = hb;
        if (to > m)   m = to;
        if (lock > m) m = lock;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/auth_timer.sv
// Shared saturating up-counter used for PIN timeout, heartbeat and lockout.
module auth_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic [W-1:0] limit_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    // Count up, hold at all-ones, restart on clear.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Expiry is flagged in the last cycle of the window so the state
    // transition lands exactly limit cycles after the clear.
    assign expire_o = (cnt_q == limit_i - 1'b1);

endmodule

// File: rtl/auth_ctrl.sv
// Rider-authorisation controller: go code, multi-byte PIN, heartbeat
// watchdog, PIN-entry timeout and lockout after repeated failures.
module auth_ctrl
    import auth_pkg::*;
#(
    parameter logic [7:0]            GO_CODE     = DEF_GO_CODE,
    parameter logic [7:0]            STOP_CODE   = DEF_STOP_CODE,
    parameter int                    KEY_LEN     = 2,
    parameter logic [8*KEY_LEN-1:0]  KEY         = 16'hA55A,
    parameter int                    HB_CYCLES   = 50_000_000,
    parameter int                    TO_CYCLES   = 25_000_000,
    parameter int                    MAX_FAILS   = 3,
    parameter int                    LOCK_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    input  logic       rider_off,
    output logic       clr_rdy,
    output logic       pwr_up,
    output logic       locked,
    output logic       auth_fail
);

    localparam int TW     = tmr_w(HB_CYCLES, TO_CYCLES, LOCK_CYCLES);
    localparam int KIDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int FW     = $clog2(MAX_FAILS + 1);

    localparam logic [TW-1:0]     HB_LIM   = TW'(HB_CYCLES);
    localparam logic [TW-1:0]     TO_LIM   = TW'(TO_CYCLES);
    localparam logic [TW-1:0]     LOCK_LIM = TW'(LOCK_CYCLES);
    localparam logic [KIDX_W-1:0] KEY_LAST = KIDX_W'(KEY_LEN - 1);
    localparam logic [FW-1:0]     FAIL_MAX = FW'(MAX_FAILS);

    state_t            state_q, state_d;
    logic [KIDX_W-1:0] key_idx_q, key_idx_d;
    logic              mismatch_q, mismatch_d;
    logic [FW-1:0]     fail_q, fail_d;
    logic              auth_fail_d;
    logic              pwr_up_q, locked_q, auth_fail_q;

    logic              tmr_clr;
    logic [TW-1:0]     tmr_limit;
    logic              expire;

    // PIN split into bytes, most-significant byte expected first.
    logic [7:0] key_bytes [KEY_LEN];
    generate
        for (genvar gi = 0; gi < KEY_LEN; gi++) begin : g_key_bytes
            assign key_bytes[gi] = KEY[8*(KEY_LEN-1-gi) +: 8];
        end
    endgenerate

    // Every byte is consumed the cycle it is presented, in every state.
    assign clr_rdy = rx_rdy;

    // Timer restarts on any transition and on bytes, except bytes during
    // lockout so a babbling link cannot extend the lockout.
    assign tmr_clr = (state_d != state_q) || (rx_rdy && (state_q != ST_LOCKED));

    // Limit follows whichever window the current state is timing.
    always_comb begin
        tmr_limit = HB_LIM;
        case (state_q)
            ST_KEY:    tmr_limit = TO_LIM;
            ST_LOCKED: tmr_limit = LOCK_LIM;
            default:   tmr_limit = HB_LIM;
        endcase
    end

    auth_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmr_clr),
        .limit_i  (tmr_limit),
        .expire_o (expire)
    );

    // Next-state logic, PIN comparison and failure accounting.
    always_comb begin
        logic fail_evt;
        logic mm;
        state_d     = state_q;
        key_idx_d   = key_idx_q;
        mismatch_d  = mismatch_q;
        fail_d      = fail_q;
        auth_fail_d = 1'b0;
        fail_evt    = 1'b0;
        mm          = mismatch_q;

        case (state_q)
            ST_OFF: begin
                if (rx_rdy && (rx_data == GO_CODE)) begin
                    state_d    = ST_KEY;
                    key_idx_d  = '0;
                    mismatch_d = 1'b0;
                end
            end
            ST_KEY: begin
                // A GO_CODE here is just another PIN byte.
                if (rx_rdy) begin
                    mm = mismatch_q | (rx_data != key_bytes[key_idx_q]);
                    if (key_idx_q == KEY_LAST) begin
                        if (!mm) begin
                            state_d = ST_ON;
                            fail_d  = '0;
                        end else begin
                            fail_evt = 1'b1;
                        end
                    end else begin
                        key_idx_d  = key_idx_q + 1'b1;
                        mismatch_d = mm;
                    end
                end else if (expire) begin
                    fail_evt = 1'b1;
                end
            end
            ST_ON: begin
                if (rx_rdy) begin
                    if (rx_data == STOP_CODE) begin
                        state_d = rider_off ? ST_OFF : ST_STOPPING;
                    end
                end else if (expire) begin
                    state_d = rider_off ? ST_OFF : ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                // Power is held until the rider leaves; GO re-arms without PIN.
                if (rx_rdy && (rx_data == GO_CODE)) begin
                    state_d = ST_ON;
                end else if (rider_off) begin
                    state_d = ST_OFF;
                end
            end
            ST_LOCKED: begin
                if (expire) begin
                    state_d = ST_OFF;
                    fail_d  = '0;
                end
            end
            default: state_d = ST_OFF;
        endcase

        if (fail_evt) begin
            fail_d      = fail_q + 1'b1;
            auth_fail_d = 1'b1;
            state_d     = (fail_d == FAIL_MAX) ? ST_LOCKED : ST_OFF;
        end
    end

    // State, PIN progress, failure count and registered output decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_OFF;
            key_idx_q   <= '0;
            mismatch_q  <= 1'b0;
            fail_q      <= '0;
            pwr_up_q    <= 1'b0;
            locked_q    <= 1'b0;
            auth_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_idx_q   <= key_idx_d;
            mismatch_q  <= mismatch_d;
            fail_q      <= fail_d;
            pwr_up_q    <= (state_d == ST_ON) || (state_d == ST_STOPPING);
            locked_q    <= (state_d == ST_LOCKED);
            auth_fail_q <= auth_fail_d;
        end
    end

    assign pwr_up    = pwr_up_q;
    assign locked    = locked_q;
    assign auth_fail = auth_fail_q;

endmodule

// File: tb/tb_auth_ctrl.sv
// Directed bench for auth_ctrl with short timer windows.
module tb_auth_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rider_off = 1'b0;
    logic       clr_rdy, pwr_up, locked, auth_fail;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    auth_ctrl #(
        .KEY_LEN     (2),
        .KEY         (16'hA55A),
        .HB_CYCLES   (100),
        .TO_CYCLES   (50),
        .MAX_FAILS   (3),
        .LOCK_CYCLES (200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .rider_off (rider_off),
        .clr_rdy   (clr_rdy),
        .pwr_up    (pwr_up),
        .locked    (locked),
        .auth_fail (auth_fail)
    );

    // Present one byte for one cycle; returns 1 time unit after the edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        #1;
        total_cnt++;
        if (clr_rdy !== 1'b1) $display("FAIL clr_rdy got=%b exp=1", clr_rdy);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        $display("byte %h: pwr_up=%b locked=%b auth_fail=%b", b, pwr_up, locked, auth_fail);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        total_cnt++;
        if ({pwr_up, locked, auth_fail, clr_rdy} !== 4'b0000)
            $display("FAIL reset_outputs got=%b exp=0000", {pwr_up, locked, auth_fail, clr_rdy});
        else pass_cnt++;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_auth_ok();
        send_byte(8'h67);
        total_cnt++;
        if ({pwr_up, auth_fail} !== 2'b00) $display("FAIL s1_after_go got=%b exp=00", {pwr_up, auth_fail});
        else pass_cnt++;
        send_byte(8'hA5);
        total_cnt++;
        if ({pwr_up, auth_fail} !== 2'b00) $display("FAIL s1_after_a5 got=%b exp=00", {pwr_up, auth_fail});
        else pass_cnt++;
        send_byte(8'h5A);
        total_cnt++;
        if ({pwr_up, auth_fail} !== 2'b10) $display("FAIL s1_power_up got=%b exp=10", {pwr_up, auth_fail});
        else pass_cnt++;
    endtask

    task automatic test_stopping();
        rider_off = 1'b0;
        send_byte(8'h73);
        total_cnt++;
        if (pwr_up !== 1'b1) $display("FAIL s2_stop_rider_on got=%b exp=1", pwr_up);
        else pass_cnt++;
        idle(3);
        total_cnt++;
        if (pwr_up !== 1'b1) $display("FAIL s2_stopping_hold got=%b exp=1", pwr_up);
        else pass_cnt++;
        rider_off = 1'b1;
        idle(1);
        total_cnt++;
        if (pwr_up !== 1'b0) $display("FAIL s2_rider_off_drop got=%b exp=0", pwr_up);
        else pass_cnt++;
        rider_off = 1'b0;
        send_byte(8'h67);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'h73);
        rider_off = 1'b1;
        send_byte(8'h67);
        total_cnt++;
        if (pwr_up !== 1'b1) $display("FAIL s2_go_beats_rider_off got=%b exp=1", pwr_up);
        else pass_cnt++;
        idle(3);
        total_cnt++;
        if (pwr_up !== 1'b1) $display("FAIL s2_on_ignores_rider_off got=%b exp=1", pwr_up);
        else pass_cnt++;
        send_byte(8'h73);
        total_cnt++;
        if (pwr_up !== 1'b0) $display("FAIL s2_stop_rider_off got=%b exp=0", pwr_up);
        else pass_cnt++;
    endtask

    task automatic test_lockout();
        for (int a = 0; a < 3; a++) begin
            send_byte(8'h67);
            send_byte(8'hA5);
            send_byte(8'h00);
            total_cnt++;
            if ({auth_fail, locked, pwr_up} !== {1'b1, (a == 2), 1'b0})
                $display("FAIL s3_attempt%0d got=%b exp=%b", a, {auth_fail, locked, pwr_up}, {1'b1, (a == 2), 1'b0});
            else pass_cnt++;
            idle(1);
            total_cnt++;
            if (auth_fail !== 1'b0) $display("FAIL s3_pulse_width%0d got=%b exp=0", a, auth_fail);
            else pass_cnt++;
        end
        send_byte(8'h67);
        total_cnt++;
        if ({locked, auth_fail, pwr_up} !== 3'b100) $display("FAIL s3_go_in_lock got=%b exp=100", {locked, auth_fail, pwr_up});
        else pass_cnt++;
        idle(197);
        total_cnt++;
        if (locked !== 1'b1) $display("FAIL s3_lock_edge199 got=%b exp=1", locked);
        else pass_cnt++;
        idle(1);
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL s3_lock_edge200 got=%b exp=0", locked);
        else pass_cnt++;
        send_byte(8'h67);
        send_byte(8'hA5);
        send_byte(8'h5A);
        total_cnt++;
        if (pwr_up !== 1'b1) $display("FAIL s3_power_after_lock got=%b exp=1", pwr_up);
        else pass_cnt++;
        send_byte(8'h73);
    endtask

    task automatic test_pin_timeout();
        send_byte(8'h67);
        send_byte(8'hA5);
        idle(49);
        total_cnt++;
        if (auth_fail !== 1'b0) $display("FAIL s4_before_timeout got=%b exp=0", auth_fail);
        else pass_cnt++;
        idle(1);
        total_cnt++;
        if ({auth_fail, pwr_up, locked} !== 3'b100) $display("FAIL s4_timeout got=%b exp=100", {auth_fail, pwr_up, locked});
        else pass_cnt++;
        send_byte(8'h5A);
        total_cnt++;
        if (pwr_up !== 1'b0) $display("FAIL s4_stray_5a got=%b exp=0", pwr_up);
        else pass_cnt++;
        // Byte arriving in the expiry cycle must win over the timeout.
        send_byte(8'h67);
        idle(49);
        send_byte(8'hA5);
        total_cnt++;
        if (auth_fail !== 1'b0) $display("FAIL s4_byte_wins got=%b exp=0", auth_fail);
        else pass_cnt++;
        send_byte(8'h5A);
        total_cnt++;
        if (pwr_up !== 1'b1) $display("FAIL s4_byte_wins_power got=%b exp=1", pwr_up);
        else pass_cnt++;
        send_byte(8'h73);
        // GO inside PIN entry is a PIN byte, so this attempt fails.
        send_byte(8'h67);
        send_byte(8'h67);
        send_byte(8'h5A);
        total_cnt++;
        if ({auth_fail, pwr_up} !== 2'b10) $display("FAIL s4_go_as_pin got=%b exp=10", {auth_fail, pwr_up});
        else pass_cnt++;
    endtask

    task automatic test_watchdog();
        rider_off = 1'b1;
        send_byte(8'h67);
        send_byte(8'hA5);
        send_byte(8'h5A);
        idle(99);
        total_cnt++;
        if (pwr_up !== 1'b1) $display("FAIL s5_wd_edge99 got=%b exp=1", pwr_up);
        else pass_cnt++;
        idle(1);
        total_cnt++;
        if (pwr_up !== 1'b0) $display("FAIL s5_wd_edge100 got=%b exp=0", pwr_up);
        else pass_cnt++;
        send_byte(8'h67);
        send_byte(8'hA5);
        send_byte(8'h5A);
        for (int i = 0; i < 17; i++) begin
            idle(59);
            send_byte(8'h00);
            total_cnt++;
            if (pwr_up !== 1'b1) $display("FAIL s5_heartbeat%0d got=%b exp=1", i, pwr_up);
            else pass_cnt++;
        end
        send_byte(8'h73);
    endtask

    task automatic test_reset_mid_op();
        rider_off = 1'b0;
        send_byte(8'h67);
        send_byte(8'hA5);
        rst = 1'b1;
        idle(1);
        total_cnt++;
        if ({pwr_up, locked, auth_fail} !== 3'b000) $display("FAIL s6_rst_mid_pin got=%b exp=000", {pwr_up, locked, auth_fail});
        else pass_cnt++;
        rst = 1'b0;
        send_byte(8'h5A);
        total_cnt++;
        if (pwr_up !== 1'b0) $display("FAIL s6_5a_after_rst got=%b exp=0", pwr_up);
        else pass_cnt++;
        send_byte(8'h67);
        send_byte(8'hA5);
        send_byte(8'h5A);
        rst = 1'b1;
        idle(1);
        total_cnt++;
        if ({pwr_up, locked, auth_fail} !== 3'b000) $display("FAIL s6_rst_while_on got=%b exp=000", {pwr_up, locked, auth_fail});
        else pass_cnt++;
        rst = 1'b0;
        send_byte(8'h5A);
        total_cnt++;
        if (pwr_up !== 1'b0) $display("FAIL s6_5a_after_rst_on got=%b exp=0", pwr_up);
        else pass_cnt++;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_auth_ok();
        test_stopping();
        test_lockout();
        test_pin_timeout();
        test_watchdog();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL timeout bench did not finish got=running exp=done");
        $fatal(1);
    end

endmodule
